// File: rtl/vga_scan_engine_if.sv
// Bundle between game logic (master) and the VGA scan engine (slave).
// pattern_sel exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_scan_engine_if #(
  parameter int NUM_RECT = 4,
  parameter int CW       = 10
);
  logic [NUM_RECT-1:0]    rect_en;
  logic [NUM_RECT*CW-1:0] rect_x;
  logic [NUM_RECT*CW-1:0] rect_y;
  logic [NUM_RECT*CW-1:0] rect_w;
  logic [NUM_RECT*CW-1:0] rect_h;
  logic [NUM_RECT*3-1:0]  rect_rgb;
  logic [2:0]             bg_rgb;
`ifdef VGA_TEST_PATTERN_EN
  logic                   pattern_sel;
`endif
  logic [2:0]             RGB;
  logic                   hsync;
  logic                   vsync;
  logic                   active;
  logic [CW-1:0]          hor_count;
  logic [CW-1:0]          ver_count;
  logic                   frame_start;
  logic                   line_start;

`ifdef VGA_TEST_PATTERN_EN
  modport master (
    output rect_en, rect_x, rect_y, rect_w, rect_h,
    output rect_rgb, bg_rgb, pattern_sel,
    input  RGB, hsync, vsync, active,
    input  hor_count, ver_count, frame_start, line_start
  );
  modport slave (
    input  rect_en, rect_x, rect_y, rect_w, rect_h,
    input  rect_rgb, bg_rgb, pattern_sel,
    output RGB, hsync, vsync, active,
    output hor_count, ver_count, frame_start, line_start
  );
`else
  modport master (
    output rect_en, rect_x, rect_y, rect_w, rect_h,
    output rect_rgb, bg_rgb,
    input  RGB, hsync, vsync, active,
    input  hor_count, ver_count, frame_start, line_start
  );
  modport slave (
    input  rect_en, rect_x, rect_y, rect_w, rect_h,
    input  rect_rgb, bg_rgb,
    output RGB, hsync, vsync, active,
    output hor_count, ver_count, frame_start, line_start
  );
`endif
endinterface

// File: rtl/vga_scan_engine.sv
// VGA raster generator with prioritised, frame-buffered rectangle overlay.
// Optional colour-bar test pattern under VGA_TEST_PATTERN_EN.
module vga_scan_engine #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int NUM_RECT  = 4,
  parameter int CW        = 10,
  parameter int BAR_SHIFT = 6
) (
  input  logic               CLK_25MH,
  input  logic               RST,
  vga_scan_engine_if.slave   bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  logic          w_hend;
  logic          w_vend;
  logic          w_load;

  assign w_hend = (r_hcount == H_LAST);
  assign w_vend = (r_vcount == V_LAST);
  assign w_load = w_hend && w_vend;

  always_ff @(posedge CLK_25MH or posedge RST) begin
    if (RST) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_hend) begin
      r_hcount <= '0;
      r_vcount <= w_vend ? '0 : r_vcount + 1'b1;
    end else begin
      r_hcount <= r_hcount + 1'b1;
    end
  end

  logic          r_en   [NUM_RECT];
  logic [CW-1:0] r_x    [NUM_RECT];
  logic [CW-1:0] r_y    [NUM_RECT];
  logic [CW-1:0] r_w    [NUM_RECT];
  logic [CW-1:0] r_h    [NUM_RECT];
  logic [2:0]    r_srgb [NUM_RECT];

  // Geometry latches on the last pixel so the new frame starts with it.
  always_ff @(posedge CLK_25MH or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        r_en[i]   <= 1'b0;
        r_x[i]    <= '0;
        r_y[i]    <= '0;
        r_w[i]    <= '0;
        r_h[i]    <= '0;
        r_srgb[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        r_en[i]   <= bus.rect_en[i];
        r_x[i]    <= bus.rect_x[i*CW +: CW];
        r_y[i]    <= bus.rect_y[i*CW +: CW];
        r_w[i]    <= bus.rect_w[i*CW +: CW];
        r_h[i]    <= bus.rect_h[i*CW +: CW];
        r_srgb[i] <= bus.rect_rgb[i*3 +: 3];
      end
    end
  end

  logic [CW:0]         w_hc;
  logic [CW:0]         w_vc;
  logic [NUM_RECT-1:0] w_hit;
  logic [2:0]          w_ovl;
  logic [2:0]          w_pix;
  logic                w_vis;
  logic                w_hs_on;
  logic                w_vs_on;

  assign w_hc = {1'b0, r_hcount};
  assign w_vc = {1'b0, r_vcount};

  // One extra bit on the far edge clips instead of wrapping.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_RECT; i++) begin
      w_hit[i] = r_en[i]
        && (w_hc >= {1'b0, r_x[i]})
        && (w_hc <  ({1'b0, r_x[i]} + {1'b0, r_w[i]}))
        && (w_vc >= {1'b0, r_y[i]})
        && (w_vc <  ({1'b0, r_y[i]} + {1'b0, r_h[i]}));
    end
  end

  always_comb begin
    w_ovl = bus.bg_rgb;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (w_hit[i]) w_ovl = r_srgb[i];
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  assign w_pix = bus.pattern_sel
    ? r_hcount[BAR_SHIFT+2:BAR_SHIFT] : w_ovl;
`else
  assign w_pix = w_ovl;
`endif

  assign w_vis   = (r_hcount < H_ACT) && (r_vcount < V_ACT);
  assign w_hs_on = (r_hcount >= HS_LO) && (r_hcount < HS_HI);
  assign w_vs_on = (r_vcount >= VS_LO) && (r_vcount < VS_HI);

  logic [2:0] r_rgb;
  logic       r_hs;
  logic       r_vs;
  logic       r_act;
  logic       r_fs;
  logic       r_ls;

  always_ff @(posedge CLK_25MH or posedge RST) begin
    if (RST) begin
      r_rgb <= 3'b000;
      r_hs  <= ~HSYNC_POL;
      r_vs  <= ~VSYNC_POL;
      r_act <= 1'b0;
      r_fs  <= 1'b0;
      r_ls  <= 1'b0;
    end else begin
      r_rgb <= w_vis ? w_pix : 3'b000;
      r_hs  <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
      r_vs  <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
      r_act <= w_vis;
      r_fs  <= (r_hcount == '0) && (r_vcount == '0);
      r_ls  <= (r_hcount == '0) && (r_vcount < V_ACT);
    end
  end

  assign bus.RGB         = r_rgb;
  assign bus.hsync       = r_hs;
  assign bus.vsync       = r_vs;
  assign bus.active      = r_act;
  assign bus.frame_start = r_fs;
  assign bus.line_start  = r_ls;
  assign bus.hor_count   = r_hcount;
  assign bus.ver_count   = r_vcount;

endmodule
